// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared state encoding and default widths for the MAC datapath
package mac_pkg;

   localparam int MULT_PROD_W = 32;
   localparam int PROD_W_DEF  = MULT_PROD_W;
   localparam int ACC_W_DEF   = 40;
   localparam int LEN_W_DEF   = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/mac_beat_counter.sv
// rtl/mac_beat_counter.sv - loadable down-counter flagging the final beat of a job
module mac_beat_counter #(
   parameter int LEN_W = mac_pkg::LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [LEN_W-1:0] len,
   input  logic             dec,
   output logic             last
);

   logic [LEN_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= len;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign last = (count == LEN_W'(1));

endmodule

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - sums a programmed number of unsigned products into a wide accumulator
module mac_accumulator
   import mac_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_acc,
   output logic              out_ovf,
   output logic              busy
);

   state_t           state;
   state_t           state_nxt;
   logic [ACC_W-1:0] acc;
   logic             ovf;
   logic [ACC_W:0]   sum;
   logic             load;
   logic             xfer;
   logic             last;

   assign in_ready = (state == ACCUM);
   assign xfer     = in_valid && in_ready;
   assign load     = start && (state == IDLE);
   // One extra bit captures the carry out of the accumulator for the sticky flag
   assign sum      = {1'b0, acc} + (ACC_W + 1)'(in_prod);

   mac_beat_counter #(.LEN_W(LEN_W)) u_beat_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .len   (len),
      .dec   (xfer),
      .last  (last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (len == '0) ? HOLD : ACCUM;
         ACCUM:   if (xfer && last) state_nxt = HOLD;
         HOLD:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         ovf <= 1'b0;
      end else if (load) begin
         acc <= '0;
         ovf <= 1'b0;
      end else if (xfer) begin
         acc <= sum[ACC_W-1:0];
         ovf <= ovf | sum[ACC_W];
      end
   end

   assign out_valid = (state == HOLD);
   assign out_acc   = out_valid ? acc : '0;
   assign out_ovf   = out_valid & ovf;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - self-checking bench for mac_accumulator (40-bit and 33-bit instances)
module tb_mac_accumulator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  len;
   logic        in_valid;
   logic [31:0] in_prod;
   logic        out_ready;

   logic        in_ready,  out_valid,  out_ovf,  busy;
   logic [39:0] out_acc;
   logic        in_ready33, out_valid33, out_ovf33, busy33;
   logic [32:0] out_acc33;

   int n_chk  = 0;
   int n_fail = 0;
   int unsigned prods[$];

   always #5 clk = ~clk;

   mac_accumulator u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
      .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
      .out_ovf(out_ovf), .busy(busy)
   );

   mac_accumulator #(.ACC_W(33)) u_dut33 (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready33), .in_prod(in_prod),
      .out_valid(out_valid33), .out_ready(out_ready), .out_acc(out_acc33),
      .out_ovf(out_ovf33), .busy(busy33)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: the job total as an exact integer, reduced per accumulator width.
   task automatic run_job(input int n, input int gap, input int hold, input bit inject, input bit junk_valid);
      longint unsigned total = 0;
      longint unsigned exp40, exp33;
      bit ovf40, ovf33;
      int t;
      foreach (prods[i]) total += prods[i];
      exp40 = total % (64'd1 << 40);
      ovf40 = (total >= (64'd1 << 40));
      exp33 = total % (64'd1 << 33);
      ovf33 = (total >= (64'd1 << 33));

      start = 1'b1;
      len   = 8'(n);
      if (junk_valid) begin
         in_valid = 1'b1;
         in_prod  = 32'hDEADBEEF;
      end
      step();
      start = 1'b0;
      len   = 8'($urandom);
      chk("busy_after_start", busy, 1);

      for (int i = 0; i < n; i++) begin
         in_valid = 1'b0;
         if (inject && i == 1) begin
            start = 1'b1;
            len   = 8'd9;
            step();
            start = 1'b0;
         end
         for (int g = 0; g < gap; g++) begin
            chk("in_ready_stall", in_ready, 1);
            step();
         end
         in_valid = 1'b1;
         in_prod  = prods[i];
         t = 0;
         while (!in_ready && t < 50) begin
            step();
            t++;
         end
         chk("in_ready_wait", in_ready, 1);
         chk("out_valid_early", out_valid, 0);
         step();
      end
      if (!junk_valid) in_valid = 1'b0;
      in_prod = $urandom;

      out_ready = 1'b0;
      for (int h = 0; h <= hold; h++) begin
         chk("out_valid", out_valid, 1);
         chk("out_valid33", out_valid33, 1);
         chk("out_acc", out_acc, exp40);
         chk("out_ovf", out_ovf, 64'(ovf40));
         chk("out_acc33", out_acc33, exp33);
         chk("out_ovf33", out_ovf33, 64'(ovf33));
         chk("in_ready_hold", in_ready, 0);
         if (h < hold) step();
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("out_valid_drop", out_valid, 0);
      chk("busy_idle", busy, 0);
      chk("in_ready_idle", in_ready, 0);
      step();
      chk("busy_stays_idle", busy, 0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_prod = '0; out_ready = 1'b0;
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_acc", out_acc, 0);
      chk("rst_out_ovf", out_ovf, 0);
      step();
      rst_n = 1'b1;
      step();

      // Reset mid-job discards the partial sum
      start = 1'b1; len = 8'd4; step(); start = 1'b0;
      in_valid = 1'b1; in_prod = 32'h10; step(); step();
      in_valid = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_out_acc", out_acc, 0);
      step();
      rst_n = 1'b1;
      step();
      prods = '{32'h5};
      run_job(1, 0, 0, 0, 0);

      // Basic sum, no stalls
      prods = '{32'h00000001, 32'h00010000, 32'hFFFFFFFF};
      run_job(3, 0, 0, 0, 0);

      // Stalls and backpressure
      prods = '{$urandom, $urandom};
      run_job(2, 3, 5, 0, 0);

      // Overflow on the 33-bit instance, then sticky flag cleared by the next start
      prods = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      run_job(3, 0, 1, 0, 0);
      prods = '{32'h1};
      run_job(1, 0, 0, 0, 0);

      // Empty job with upstream already presenting a beat
      prods = {};
      run_job(0, 0, 2, 0, 1);

      // Start during ACCUM is ignored
      prods = '{$urandom, $urandom};
      run_job(2, 1, 0, 1, 0);

      // Maximum length job
      prods = {};
      for (int i = 0; i < 255; i++) prods.push_back(32'hFFFFFFFF);
      run_job(255, 0, 0, 0, 0);

      // Random jobs
      for (int j = 0; j < 6; j++) begin
         int n;
         n = $urandom_range(12, 1);
         prods = {};
         for (int i = 0; i < n; i++) prods.push_back($urandom);
         run_job(n, $urandom_range(2, 0), $urandom_range(3, 0), 0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
